// File: rtl/l2_port_arbiter.sv
// rtl/l2_port_arbiter.sv - shares the DL2cache request port between the L1 I-miss and D-miss paths
module l2_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              d_flush_req,
  output logic              d_flush_ack,
  output logic [ADDR_W-1:0] l2_addr,
  output logic              l2_en,
  output logic              l2_we,
  output logic [DATA_W-1:0] l2_din,
  output logic              l2_flush,
  input  logic [DATA_W-1:0] l2_dout,
  input  logic              l2_dready,
  input  logic              l2_accepting
);

  typedef enum logic [2:0] {IDLE, GAP, WAIT_RD, FL_GAP, FL_WAIT} state_t;

  state_t state;
  logic   rr_last;  // 1 = D side won the last arbitration
  logic   owner;    // 1 = D side owns the outstanding read
  logic   pick_d;
  logic   flush_go;

  always_comb begin
    pick_d   = d_req && (!i_req || !rr_last);
    // The requester still holds d_flush_req in the cycle the ack is visible.
    flush_go = d_flush_req && !d_flush_ack;
  end

  always_comb begin
    i_rvalid = (state == WAIT_RD) && l2_dready && !owner;
    d_rvalid = (state == WAIT_RD) && l2_dready && owner;
    i_rdata  = i_rvalid ? l2_dout : '0;
    d_rdata  = d_rvalid ? l2_dout : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_last     <= 1'b1;
      owner       <= 1'b0;
      l2_en       <= 1'b0;
      l2_we       <= 1'b0;
      l2_flush    <= 1'b0;
      i_gnt       <= 1'b0;
      d_gnt       <= 1'b0;
      d_flush_ack <= 1'b0;
      l2_addr     <= '0;
      l2_din      <= '0;
    end else begin
      l2_en       <= 1'b0;
      l2_we       <= 1'b0;
      l2_flush    <= 1'b0;
      i_gnt       <= 1'b0;
      d_gnt       <= 1'b0;
      d_flush_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (l2_accepting) begin
            if (flush_go) begin
              l2_flush <= 1'b1;
              state    <= FL_GAP;
            end else if (i_req || d_req) begin
              rr_last <= pick_d;
              if (pick_d) begin
                d_gnt   <= 1'b1;
                l2_addr <= d_addr;
                if (d_we) begin
                  l2_we  <= 1'b1;
                  l2_din <= d_wdata;
                  state  <= GAP;
                end else begin
                  l2_en <= 1'b1;
                  owner <= 1'b1;
                  state <= WAIT_RD;
                end
              end else begin
                i_gnt   <= 1'b1;
                l2_addr <= i_addr;
                l2_en   <= 1'b1;
                owner   <= 1'b0;
                state   <= WAIT_RD;
              end
            end
          end
        end
        // L2 accepting lags the strobe by one cycle, so skip a cycle before re-arbitrating.
        GAP:     state <= IDLE;
        WAIT_RD: if (l2_dready) state <= GAP;
        FL_GAP:  state <= FL_WAIT;
        FL_WAIT: begin
          if (l2_accepting) begin
            d_flush_ack <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb/tb_l2_port_arbiter.sv - scoreboard bench for l2_port_arbiter
module tb_l2_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;

  localparam logic [7:0] M_IG = 8'h80, M_DG = 8'h40, M_IR = 8'h20, M_DR = 8'h10;
  localparam logic [7:0] M_FL = 8'h08, M_AK = 8'h04, M_EN = 8'h02, M_WE = 8'h01;

  typedef struct packed {
    logic [7:0]    mask;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          d_flush_req, d_flush_ack;
  logic [AW-1:0] l2_addr;
  logic          l2_en, l2_we, l2_flush;
  logic [DW-1:0] l2_din, l2_dout;
  logic          l2_dready, l2_accepting;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  rd_lat = 1;
  ev_t exp_q[$];

  l2_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_flush_req(d_flush_req), .d_flush_ack(d_flush_ack),
    .l2_addr(l2_addr), .l2_en(l2_en), .l2_we(l2_we), .l2_din(l2_din), .l2_flush(l2_flush),
    .l2_dout(l2_dout), .l2_dready(l2_dready), .l2_accepting(l2_accepting)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] resp(input logic [AW-1:0] a);
    if (a == 32'h1000) return {8{8'hA5}};
    return {a, ~a};
  endfunction

  task automatic push(input logic [7:0] m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back('{mask: m, addr: a, data: d});
  endtask

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return i_gnt;
      1: return d_gnt;
      2: return l2_flush;
      3: return d_flush_ack;
      default: return l2_dready;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig(which) && n < 200);
    checks++;
    if (!sig(which)) begin
      errors++;
      $display("FAIL %s timeout got=0 want=1", name);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_i_gnt"}, DW'(i_gnt), 0);
    check({tag, "_d_gnt"}, DW'(d_gnt), 0);
    check({tag, "_l2_en"}, DW'(l2_en), 0);
    check({tag, "_l2_we"}, DW'(l2_we), 0);
    check({tag, "_l2_flush"}, DW'(l2_flush), 0);
    check({tag, "_flush_ack"}, DW'(d_flush_ack), 0);
    check({tag, "_l2_addr"}, DW'(l2_addr), 0);
    check({tag, "_l2_din"}, l2_din, 0);
    check({tag, "_rvalid"}, DW'({i_rvalid, d_rvalid}), 0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // L2 model: one response per read strobe, rd_lat cycles after the strobe cycle.
  initial begin
    logic [AW-1:0] a;
    l2_dready = 1'b0;
    l2_dout   = '0;
    forever begin
      @(negedge clk);
      if (l2_en) begin
        a = l2_addr;
        repeat (rd_lat) @(posedge clk);
        #1;
        l2_dready = 1'b1;
        l2_dout   = resp(a);
        @(posedge clk);
        #1;
        l2_dready = 1'b0;
        l2_dout   = '0;
      end
    end
  end

  // Monitor: every visible output event is matched in order against the scoreboard.
  initial begin
    ev_t obs, e;
    int  last_wr = -100;
    forever begin
      @(negedge clk);
      if (!reset) begin
        obs.mask = {i_gnt, d_gnt, i_rvalid, d_rvalid, l2_flush, d_flush_ack, l2_en, l2_we};
        if (obs.mask != 8'h00) begin
          obs.addr = (l2_en || l2_we) ? l2_addr : '0;
          obs.data = i_rvalid ? i_rdata : d_rvalid ? d_rdata : l2_we ? l2_din : '0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got mask=%b addr=%0h data=%0h want none", obs.mask, obs.addr, obs.data);
          end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
              errors++;
              $display("FAIL event got mask=%b addr=%0h data=%0h want mask=%b addr=%0h data=%0h",
                       obs.mask, obs.addr, obs.data, e.mask, e.addr, e.data);
            end
          end
          if (l2_en || l2_we) begin
            if (cyc - last_wr < 2) begin
              checks++;
              errors++;
              $display("FAIL write_spacing got=%0d want>=2", cyc - last_wr);
            end
            if (l2_we) last_wr = cyc;
          end
        end
      end
    end
  end

  initial begin
    int viol;
    int n;
    reset = 1'b1;
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_flush_req = 0;
    l2_accepting = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;

    // 1: single I read with hit latency
    @(negedge clk);
    i_addr = 32'h1000;
    i_req = 1'b1;
    push(M_IG | M_EN, 32'h1000, '0);
    push(M_IR, '0, {8{8'hA5}});
    wait_sig(0, "t1_i_gnt");
    i_req = 1'b0;
    repeat (6) @(negedge clk);

    // 2: both sides requesting from reset alternate I,D,I,D,I,D
    do_reset();
    i_addr = 32'h1100; i_req = 1'b1;
    d_addr = 32'h2100; d_we = 1'b0; d_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(M_IG | M_EN, 32'h1100, '0);
      push(M_IR, '0, resp(32'h1100));
      push(M_DG | M_EN, 32'h2100, '0);
      push(M_DR, '0, resp(32'h2100));
    end
    n = 0;
    viol = 0;
    while (n < 6 && viol < 400) begin
      @(negedge clk);
      viol++;
      if (i_gnt || d_gnt) n++;
    end
    check("t2_grant_count", DW'(n), 6);
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (8) @(negedge clk);

    // 3: D write, then an I read must wait out the gap
    d_we = 1'b1; d_addr = 32'h2000; d_wdata = 64'h1234; d_req = 1'b1;
    push(M_DG | M_WE, 32'h2000, 64'h1234);
    push(M_IG | M_EN, 32'h1300, '0);
    push(M_IR, '0, resp(32'h1300));
    wait_sig(1, "t3_d_gnt");
    d_req = 1'b0;
    i_addr = 32'h1300; i_req = 1'b1;
    wait_sig(0, "t3_i_gnt");
    i_req = 1'b0;
    repeat (6) @(negedge clk);

    // 4: flush and I request queued behind an outstanding D miss
    rd_lat = 8;
    d_we = 1'b0; d_addr = 32'h2400; d_req = 1'b1;
    push(M_DG | M_EN, 32'h2400, '0);
    push(M_DR, '0, resp(32'h2400));
    push(M_FL, '0, '0);
    push(M_AK, '0, '0);
    push(M_IG | M_EN, 32'h1400, '0);
    push(M_IR, '0, resp(32'h1400));
    wait_sig(1, "t4_d_gnt");
    d_req = 1'b0;
    d_flush_req = 1'b1;
    i_addr = 32'h1400; i_req = 1'b1;
    wait_sig(2, "t4_flush");
    l2_accepting = 1'b0;
    rd_lat = 1;
    repeat (20) @(negedge clk);
    l2_accepting = 1'b1;
    @(negedge clk);
    check("t4_flush_ack_first_accepting", DW'(d_flush_ack), 1);
    d_flush_req = 1'b0;
    wait_sig(0, "t4_i_gnt");
    i_req = 1'b0;
    repeat (6) @(negedge clk);

    // 5: no issue while L2 is not accepting
    l2_accepting = 1'b0;
    i_addr = 32'h1500; i_req = 1'b1;
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (i_gnt || l2_en) viol++;
    end
    check("t5_stalled_issues", DW'(viol), 0);
    push(M_IG | M_EN, 32'h1500, '0);
    push(M_IR, '0, resp(32'h1500));
    l2_accepting = 1'b1;
    @(negedge clk);
    check("t5_i_gnt_first_accepting", DW'(i_gnt), 1);
    i_req = 1'b0;
    repeat (6) @(negedge clk);

    // 6: reset during WAIT_RD drops the stale response
    rd_lat = 5;
    i_addr = 32'h1600; i_req = 1'b1;
    push(M_IG | M_EN, 32'h1600, '0);
    wait_sig(0, "t6_i_gnt");
    i_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_quiet("t6_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_sig(4, "t6_stale_dready");
    check("t6_stale_rvalid", DW'({i_rvalid, d_rvalid}), 0);
    rd_lat = 1;
    repeat (3) @(negedge clk);
    i_addr = 32'h1700; i_req = 1'b1;
    push(M_IG | M_EN, 32'h1700, '0);
    push(M_IR, '0, resp(32'h1700));
    wait_sig(0, "t6_i_gnt_after_reset");
    i_req = 1'b0;

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", DW'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
